// File: rtl/ctech_lib_clk_gate_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : ctech_lib_clk_gate_ctrl_pkg
// Brief    : Shared channel-state encoding and default timing constants.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ctech_lib_clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } chan_state_e;

    localparam int c_WAKE_CYC_DEF = 2;
    localparam int c_HOLD_W_DEF   = 8;

endpackage

`default_nettype wire

// File: rtl/ctech_lib_clk_gate_chan.sv
//------------------------------------------------------------------------------
// Module   : ctech_lib_clk_gate_chan
// Brief    : Per-channel OFF/WAKE/ON/HOLD handshake FSM with wake/hold counter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ctech_lib_clk_gate_chan
    import ctech_lib_clk_gate_ctrl_pkg::*;
#(
    parameter int WAKE_CYC = c_WAKE_CYC_DEF,
    parameter int HOLD_W   = c_HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req,
    input  logic [HOLD_W-1:0] hold_cfg,
    output logic              en,
    output logic              ack
);

    localparam logic [1:0] c_ST_OFF  = ST_OFF;
    localparam logic [1:0] c_ST_WAKE = ST_WAKE;
    localparam logic [1:0] c_ST_ON   = ST_ON;
    localparam logic [1:0] c_ST_HOLD = ST_HOLD;

    // One counter serves both phases; it must fit the wake load as well as hold_cfg.
    localparam int              c_CNT_W     = (HOLD_W > 3) ? HOLD_W : 3;
    localparam logic [c_CNT_W-1:0] c_WAKE_LOAD = c_CNT_W'(WAKE_CYC - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_hold_load;
    logic               r_en;
    logic               r_ack;

    assign w_hold_load = c_CNT_W'(hold_cfg);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_OFF: begin
                if (req) begin
                    w_state_nxt = c_ST_WAKE;
                    w_cnt_nxt   = c_WAKE_LOAD;
                end
            end
            c_ST_WAKE: begin
                if (!req) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = w_hold_load;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_ST_ON;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_ON: begin
                if (!req) begin
                    if (hold_cfg == '0) begin
                        w_state_nxt = c_ST_OFF;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = c_ST_HOLD;
                        w_cnt_nxt   = w_hold_load;
                    end
                end
            end
            c_ST_HOLD: begin
                // A zero count (entered from WAKE with hold_cfg=0) also exits, never wraps.
                if (req) begin
                    w_state_nxt = c_ST_ON;
                    w_cnt_nxt   = '0;
                end else if (r_cnt <= c_CNT_W'(1)) begin
                    w_state_nxt = c_ST_OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Enable and ack get their own flops so no state-decode glitch reaches the gate.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= c_ST_OFF;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= (w_state_nxt != c_ST_OFF);
            r_ack   <= (w_state_nxt == c_ST_ON);
        end
    end

    assign en  = r_en;
    assign ack = r_ack;

endmodule

`default_nettype wire

// File: rtl/ctech_lib_clk_gate_te.sv
//------------------------------------------------------------------------------
// Module   : ctech_lib_clk_gate_te
// Brief    : Latch-based integrated clock gate with test-enable override.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ctech_lib_clk_gate_te (
    input  logic clk,
    input  logic en,
    input  logic te,
    output logic clkout
);

    logic r_lat;

    // Transparent only while clk is low, so the enable cannot chop a high phase.
    always_latch begin
        if (!clk) begin
            r_lat = en | te;
        end
    end

    assign clkout = clk & r_lat;

endmodule

`default_nettype wire

// File: rtl/ctech_lib_clk_gate_ctrl.sv
//------------------------------------------------------------------------------
// Module   : ctech_lib_clk_gate_ctrl
// Brief    : NUM_CH independent request/ack clock-gate controllers.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ctech_lib_clk_gate_ctrl
    import ctech_lib_clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WAKE_CYC = c_WAKE_CYC_DEF,
    parameter int HOLD_W   = c_HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              te,
    input  logic [NUM_CH-1:0] req,
    input  logic [HOLD_W-1:0] hold_cfg,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] clk_active
);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            ctech_lib_clk_gate_chan #(
                .WAKE_CYC (WAKE_CYC),
                .HOLD_W   (HOLD_W)
            ) u_chan (
                .clk      (clk),
                .rst_b    (rst_b),
                .req      (req[i]),
                .hold_cfg (hold_cfg),
                .en       (clk_active[i]),
                .ack      (ack[i])
            );

            ctech_lib_clk_gate_te u_cg (
                .clk    (clk),
                .en     (clk_active[i]),
                .te     (te),
                .clkout (clkout[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ctech_lib_clk_gate_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_ctech_lib_clk_gate_ctrl
// Brief    : Directed scoreboard bench for ctech_lib_clk_gate_ctrl.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ctech_lib_clk_gate_ctrl;

    logic       clk;
    logic       rst_b;
    logic       te;
    logic [3:0] req;
    logic [7:0] hold_cfg;
    logic [3:0] clkout;
    logic [3:0] ack;
    logic [3:0] clk_active;

    typedef struct {
        int         id;
        logic [3:0] act;
        logic [3:0] ack;
        logic [3:0] ck;
        logic       chk_ck;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         vec_id   = 0;
    logic [3:0] prev_act = 4'h0;

    ctech_lib_clk_gate_ctrl #(
        .NUM_CH   (4),
        .WAKE_CYC (2),
        .HOLD_W   (8)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .te         (te),
        .req        (req),
        .hold_cfg   (hold_cfg),
        .clkout     (clkout),
        .ack        (ack),
        .clk_active (clk_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    // clkout is sampled in the high phase, so it reflects the enable held before that edge.
    task automatic cyc(input logic [3:0] r, input logic t, input logic rb,
                       input logic [7:0] h, input logic [3:0] ea, input logic [3:0] ek);
        exp_t e;
        @(negedge clk);
        req      = r;
        te       = t;
        rst_b    = rb;
        hold_cfg = h;
        e.id     = vec_id;
        e.act    = ea;
        e.ack    = ek;
        e.ck     = prev_act | {4{t}};
        e.chk_ck = (vec_id >= 2);
        sb_q.push_back(e);
        prev_act = ea;
        vec_id++;
    endtask

    task automatic check(input string name, input int id, input logic [3:0] act_v, input logic [3:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, id, act_v, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("clk_active", e.id, clk_active, e.act);
                check("ack", e.id, ack, e.ack);
                if (e.chk_ck) check("clkout", e.id, clkout, e.ck);
            end
        end
    end

    initial begin : stim
        rst_b    = 1'b0;
        te       = 1'b0;
        req      = 4'h0;
        hold_cfg = 8'd0;
        // reset
        repeat (3) cyc(4'h0, 0, 0, 8'd0, 4'h0, 4'h0);
        // ch0 wake: enable on first edge, ack WAKE_CYC edges later
        cyc(4'h1, 0, 1, 8'd5, 4'h1, 4'h0);
        cyc(4'h1, 0, 1, 8'd5, 4'h1, 4'h0);
        cyc(4'h1, 0, 1, 8'd5, 4'h1, 4'h1);
        cyc(4'h1, 0, 1, 8'd5, 4'h1, 4'h1);
        // ch1 on, then release with hold_cfg=5; hold_cfg changed mid-hold
        cyc(4'h3, 0, 1, 8'd5, 4'h3, 4'h1);
        cyc(4'h3, 0, 1, 8'd5, 4'h3, 4'h1);
        cyc(4'h3, 0, 1, 8'd5, 4'h3, 4'h3);
        cyc(4'h1, 0, 1, 8'd5, 4'h3, 4'h1);
        repeat (4) cyc(4'h1, 0, 1, 8'd200, 4'h3, 4'h1);
        cyc(4'h1, 0, 1, 8'd200, 4'h1, 4'h1);
        cyc(4'h1, 0, 1, 8'd5, 4'h1, 4'h1);
        // ch2 on, release, re-request with 3 hold cycles left
        cyc(4'h5, 0, 1, 8'd5, 4'h5, 4'h1);
        cyc(4'h5, 0, 1, 8'd5, 4'h5, 4'h1);
        cyc(4'h5, 0, 1, 8'd5, 4'h5, 4'h5);
        cyc(4'h1, 0, 1, 8'd5, 4'h5, 4'h1);
        cyc(4'h1, 0, 1, 8'd5, 4'h5, 4'h1);
        cyc(4'h1, 0, 1, 8'd5, 4'h5, 4'h1);
        cyc(4'h5, 0, 1, 8'd5, 4'h5, 4'h5);
        cyc(4'h5, 0, 1, 8'd5, 4'h5, 4'h5);
        // ch3 with hold_cfg=0: direct off, then one-cycle pulse WAKE->HOLD->OFF
        cyc(4'hD, 0, 1, 8'd0, 4'hD, 4'h5);
        cyc(4'hD, 0, 1, 8'd0, 4'hD, 4'h5);
        cyc(4'hD, 0, 1, 8'd0, 4'hD, 4'hD);
        cyc(4'h5, 0, 1, 8'd0, 4'h5, 4'h5);
        cyc(4'hD, 0, 1, 8'd0, 4'hD, 4'h5);
        cyc(4'h5, 0, 1, 8'd0, 4'hD, 4'h5);
        cyc(4'h5, 0, 1, 8'd0, 4'h5, 4'h5);
        cyc(4'h5, 0, 1, 8'd0, 4'h5, 4'h5);
        cyc(4'h0, 0, 1, 8'd0, 4'h0, 4'h0);
        cyc(4'h0, 0, 1, 8'd0, 4'h0, 4'h0);
        // test enable opens every gate without touching state
        repeat (3) cyc(4'h0, 1, 1, 8'd0, 4'h0, 4'h0);
        repeat (2) cyc(4'h0, 0, 1, 8'd0, 4'h0, 4'h0);
        // all channels request, reset mid-wake, then re-request
        cyc(4'hF, 0, 1, 8'd0, 4'hF, 4'h0);
        cyc(4'hF, 0, 0, 8'd0, 4'h0, 4'h0);
        cyc(4'hF, 0, 1, 8'd0, 4'hF, 4'h0);
        cyc(4'hF, 0, 1, 8'd0, 4'hF, 4'h0);
        cyc(4'hF, 0, 1, 8'd0, 4'hF, 4'hF);
        cyc(4'hF, 1, 1, 8'd0, 4'hF, 4'hF);
        cyc(4'h0, 0, 1, 8'd0, 4'h0, 4'h0);
        cyc(4'h0, 0, 1, 8'd0, 4'h0, 4'h0);
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ctech_lib_clk_gate_ctrl.md
CTECH_LIB_CLK_GATE_CTRL -- requirements
Module: ctech_lib_clk_gate_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of independently gated clock channels (1..32).
REQ-002 Parameter WAKE_CYC, default 2: cycles from gate enable to ack (1..7).
REQ-003 Parameter HOLD_W, default 8: width of the idle hold-off counter and its configuration input.
REQ-004 clk  input  1  free-running source clock for all channels and control logic.
REQ-005 rst_b  input  1  reset; synchronous and active-low, sampled on rising clk.
REQ-006 te  input  1  scan/test enable; forces every gate transparent.
REQ-007 req  input  NUM_CH  per-channel clock request, level, four-phase.
REQ-008 hold_cfg  input  HOLD_W  idle cycles a channel stays enabled after req falls; sampled when the channel enters HOLD.
REQ-009 clkout  output  NUM_CH  gated clocks.
REQ-010 ack  output  NUM_CH  per-channel grant: gated clock is running and stable.
REQ-011 clk_active  output  NUM_CH  registered gate-enable state per channel (1 = enable asserted).

Function
REQ-012 Each channel SHALL run an independent FSM with states OFF, WAKE, ON and HOLD.
REQ-013 OFF: enable=0, ack=0; req=1 -> WAKE, loading the wake counter with WAKE_CYC-1.
REQ-014 WAKE: enable=1, ack=0; counter decrements each cycle; at 0 -> ON; req=0 while in WAKE -> HOLD.
REQ-015 ON: enable=1, ack=1; req=0 -> HOLD, loading the hold counter with hold_cfg; if hold_cfg=0 -> OFF directly.
REQ-016 HOLD: enable=1, ack=0; counter decrements each cycle; req=1 -> ON (ack=1 next cycle, no wake delay); counter=1 and req=0 -> OFF.
REQ-017 Gate-enable latency: enable asserts on the clk edge after req is first sampled high in OFF; ack follows WAKE_CYC edges later.
REQ-018 ack SHALL deassert on the edge after req is sampled low (four-phase return-to-zero).
REQ-019 Gate enable SHALL be driven from a flop, never combinationally from req, so the gate enable is glitch-free.
REQ-020 clkout[i] SHALL toggle with clk whenever clk_active[i]=1 or te=1, and be held low otherwise.
REQ-021 te SHALL NOT alter FSM state, counters, ack or clk_active.
REQ-022 Channels SHALL NOT interact; simultaneous req edges on all channels are handled identically and in parallel.
REQ-023 A change of hold_cfg while a channel is in HOLD SHALL NOT affect the running count.
REQ-024 Counters SHALL never underflow or wrap; the maximum hold is 2^HOLD_W-1 cycles.

Reset
REQ-025 While rst_b=0 at a clk edge, all channels SHALL go to OFF, with counters=0, ack=0 and clk_active=0.
REQ-026 A reset arriving mid-WAKE or mid-HOLD SHALL abort the state on that edge; clkout stops after the gate's latch phase unless te=1.
REQ-027 After reset release, the first req=1 SHALL follow REQ-017 timing exactly.

Structure
REQ-028 A shared package SHALL hold the channel-state enum (OFF, WAKE, ON, HOLD) and the default constants for WAKE_CYC and HOLD_W.
REQ-029 The per-channel FSM and counters SHALL be a sub-module, ctech_lib_clk_gate_chan, generated NUM_CH times.
REQ-030 Each channel SHALL instantiate one ctech_lib_clk_gate_te cell with .clk(clk), .en(clk_active[i]), .te(te) and .clkout(clkout[i]).

Verification
REQ-031 Reset with req=0; raise req[0] at cycle 10 with WAKE_CYC=2 -> clk_active[0]=1 at cycle 11, ack[0]=1 at cycle 13, clkout[0] toggling from cycle 11.
REQ-032 hold_cfg=5; drop req[1] while in ON -> ack[1]=0 next cycle; clk_active[1] stays 1 for 5 cycles, then 0; clkout[1] low after that.
REQ-033 In HOLD with 3 cycles left, re-raise req -> ack=1 next cycle and clk_active never drops.
REQ-034 hold_cfg=0, drop req -> OFF on the next edge; pulse req=1 for 1 cycle from OFF -> WAKE, then HOLD, then OFF, with no ack.
REQ-035 te=1 with all req=0 -> all clkout toggling, ack=0, clk_active=0; then te=0 -> all clkout low.
REQ-036 All 4 channels request together, then rst_b=0 mid-WAKE for 1 cycle -> all states OFF, ack=0; after release, req held high -> ack=1 at WAKE_CYC+1 cycles.
